inst_line_filler: RTL and testbench
===================================

Name: inst_line_filler

Overview:
Memory-side line fill engine sitting directly downstream of inst_cache. It takes the cache's line-read request (addr/rd/ack with a 256-bit line) and performs LINE_WORDS sequential single-word reads on the 32-bit memory bus. It assembles the words into one line and returns it to the cache with a one-cycle ack pulse.

Parameters:
LINE_WORDS, 8, words per cache line; power of two, 2..16; line width is 32*LINE_WORDS bits (256 at default).

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  reset; synchronous, active-high.
addr_i  input  32  line request address from inst_cache; low offset bits are ignored.
rd_i  input  1  line read request, level; held by the requester until it sees ack_o.
data_o  output  32*LINE_WORDS  assembled line; word k occupies bits [32k+31:32k].
ack_o  output  1  one-cycle pulse; data_o is valid in the same cycle.
mem_addr_o  output  32  word address on the memory bus; always word-aligned.
mem_rd_o  output  1  memory read strobe.
mem_data_i  input  32  memory read data.
mem_valid_i  input  1  memory read data valid; ignored while mem_rd_o=0.

Behaviour:
- Reset values (applied at the first posedge with rst=1): state=IDLE, ack_o=0, mem_rd_o=0, mem_addr_o=0, data_o=0, word index=0.
- Offset width is OFF=log2(LINE_WORDS)+2. Line base = addr_i with bits [OFF-1:0] cleared. The base is latched on acceptance and is not re-sampled during the fill.
- State IDLE:
  - mem_rd_o=0.
  - If rd_i=1: latch base, set idx=0, go to READ.
- State READ:
  - mem_rd_o=1 and mem_addr_o=base+{idx,2'b00}, both registered and stable until the word is taken.
  - On the posedge with mem_valid_i=1: line word[idx] <= mem_data_i and idx increments.
  - When idx=LINE_WORDS-1 is taken, go to DONE.
  - Zero-wait memory is legal: mem_valid_i may be high in the first READ cycle.
- State DONE:
  - ack_o=1 and mem_rd_o=0 for exactly one cycle, then go to IDLE.
  - The requester must drop rd_i at the posedge ending the ack cycle.
  - rd_i is not sampled in DONE, so no re-trigger is possible.
- Latency with zero-wait memory:
  - rd_i is sampled in cycle 0.
  - READ occupies cycles 1..LINE_WORDS.
  - ack_o is asserted in cycle LINE_WORDS+1 (cycle 9 at default).
  - The next request can be accepted in cycle LINE_WORDS+2.
  - Each memory wait cycle adds exactly one cycle.
- data_o is a register. It holds the last completed line unchanged until the next fill writes it. Words from a new fill may overwrite data_o progressively; data_o is guaranteed coherent only during ack_o.
- Address arithmetic is confined to the offset field and never carries into the base. Base 0xFFFFFFE0 yields last address 0xFFFFFFFC with no wrap to 0.
- mem_valid_i in IDLE or DONE is ignored, with no state change.
- rd_i changing during READ is ignored.
- Reset mid-fill: synchronous abort to IDLE, the partial line is discarded (data_o=0), and no ack is issued. A request after reset starts at word 0.
- There are no error or timeout paths. A memory that never returns valid stalls the fill; this is accepted.

Decomposition:
- Shared package (soc_pkg):
  - fill-state enum {IDLE, READ, DONE};
  - LINE_WORDS_DEFAULT=8;
  - a function computing offset width from LINE_WORDS;
  - a line-width constant shared with inst_cache.
- No sub-module: a single FSM plus a line register and an index counter; no instance split is natural.

Test Plan:
- Zero-wait fill: addr_i=0x00000047, memory returns 0x1000+k → mem_addr_o steps 0x40,0x44,…,0x5C; ack_o high only in cycle 9; data_o word k=0x1000+k.
- Wait states: mem_valid_i high every 3rd cycle → mem_addr_o stays constant between valids; exactly 8 captures; a single ack pulse; line correct.
- Top-of-space: addr_i=0xFFFFFFF0 → addresses 0xFFFFFFE0..0xFFFFFFFC, never 0x00000000.
- Reset after 3 words: rst=1 for one cycle → next cycle mem_rd_o=0, ack_o=0, data_o=0. A subsequent request with addr 0x100 fetches from 0x100 with word 0 first.
- Back-to-back: rd_i reasserted in the cycle after ack for line 0x20 → no duplicate ack; the second ack delivers the 0x20–0x3C data.
- Spurious valid: mem_valid_i=1 with data 0xDEADBEEF while IDLE → no state change and data_o unchanged.

Source files
------------

// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared fill-state type and cache line geometry
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } fill_state_e;

    localparam int LINE_WORDS_DEFAULT = 8;
    // Shared with inst_cache so both sides agree on the line bus width.
    localparam int LINE_BITS = 32 * LINE_WORDS_DEFAULT;

    function automatic int off_width(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/inst_line_filler_if.sv
// rtl/inst_line_filler_if.sv - cache line request and memory word bus
interface inst_line_filler_if #(
    parameter int LINE_WORDS = soc_pkg::LINE_WORDS_DEFAULT
);
    logic [31:0]              addr_i;
    logic                     rd_i;
    logic [32*LINE_WORDS-1:0] data_o;
    logic                     ack_o;
    logic [31:0]              mem_addr_o;
    logic                     mem_rd_o;
    logic [31:0]              mem_data_i;
    logic                     mem_valid_i;

    modport slave (
        input  addr_i,
        input  rd_i,
        output data_o,
        output ack_o,
        output mem_addr_o,
        output mem_rd_o,
        input  mem_data_i,
        input  mem_valid_i
    );

    modport master (
        output addr_i,
        output rd_i,
        input  data_o,
        input  ack_o,
        input  mem_addr_o,
        input  mem_rd_o,
        output mem_data_i,
        output mem_valid_i
    );
endinterface

// File: rtl/inst_line_filler.sv
// rtl/inst_line_filler.sv - fills one cache line with sequential word reads
module inst_line_filler
    import soc_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_line_filler_if.slave     bus
);

    localparam int OFF  = off_width(LINE_WORDS);
    localparam int IDXW = $clog2(LINE_WORDS);
    localparam logic [31:0] OFF_MASK = 32'((64'd1 << OFF) - 64'd1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LINE_WORDS - 1);

    fill_state_e     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] idx_nxt;
    logic [31:0]     line_q [LINE_WORDS];
    logic [31:0]     line_d [LINE_WORDS];
    logic            ack_q, ack_d;
    logic            mem_rd_q, mem_rd_d;
    logic [31:0]     mem_addr_q, mem_addr_d;

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        line_d     = line_q;
        ack_d      = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                mem_rd_d = 1'b0;
                if (bus.rd_i) begin
                    state_d    = READ;
                    idx_d      = '0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = bus.addr_i & ~OFF_MASK;
                end
            end
            READ: begin
                if (bus.mem_valid_i) begin
                    line_d[idx_q] = bus.mem_data_i;
                    idx_d         = idx_nxt;
                    if (idx_q == LAST_IDX) begin
                        state_d  = DONE;
                        mem_rd_d = 1'b0;
                        ack_d    = 1'b1;
                    end else begin
                        // Only the offset field advances, so the base can never carry.
                        mem_addr_d = {mem_addr_q[31:OFF], idx_nxt, 2'b00};
                    end
                end
            end
            DONE: begin
                mem_rd_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                mem_rd_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ack_q      <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ack_q      <= ack_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            line_q     <= line_d;
        end
    end

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_pack
        assign bus.data_o[32*g +: 32] = line_q[g];
    end

    assign bus.ack_o      = ack_q;
    assign bus.mem_rd_o   = mem_rd_q;
    assign bus.mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_inst_line_filler.sv
// tb/tb_inst_line_filler.sv - self-checking bench for inst_line_filler
module tb_inst_line_filler;
    import soc_pkg::*;

    localparam int LW = LINE_WORDS_DEFAULT;
    localparam int LB = 32 * LW;
    localparam logic [31:0] OMASK = 32'(LW * 4 - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_line_filler_if #(.LINE_WORDS(LW)) bus ();
    inst_line_filler #(.LINE_WORDS(LW)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    int          wmode = 0;
    bit          spur = 1'b0;
    int          wcnt = 0;
    logic [31:0] addr_log[$];
    int          acks = 0;
    int          stable_err = 0;
    bit          prev_rd = 1'b0;
    bit          prev_valid = 1'b0;
    logic [31:0] prev_addr = '0;

    typedef struct {
        logic [31:0] addr;
        int          wm;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    function automatic logic [31:0] mem_fn(input logic [31:0] x);
        if (x[31:5] == 27'h2) return 32'h1000 + {29'd0, x[4:2]};
        return (x * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [LB-1:0] model_line(input logic [31:0] a);
        logic [LB-1:0] l;
        logic [31:0]   b;
        b = a & ~OMASK;
        for (int k = 0; k < LW; k++) l[k*32 +: 32] = mem_fn(b + 32'(4 * k));
        return l;
    endfunction

    // Memory responder and bus monitor share one process so their view is consistent.
    always @(negedge clk) begin
        bit v;
        if (bus.mem_rd_o) begin
            case (wmode)
                0:       v = 1'b1;
                1:       v = (wcnt % 3 == 2);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            wcnt++;
        end else begin
            v = spur || (wmode == 2 && $urandom_range(0, 3) == 0);
        end
        bus.mem_valid_i = v;
        if (spur && !bus.mem_rd_o)  bus.mem_data_i = 32'hDEADBEEF;
        else if (v && bus.mem_rd_o) bus.mem_data_i = mem_fn(bus.mem_addr_o);
        else                        bus.mem_data_i = $urandom;
        if (bus.mem_rd_o && v) addr_log.push_back(bus.mem_addr_o);
        if (prev_rd && !prev_valid && bus.mem_rd_o && bus.mem_addr_o != prev_addr) stable_err++;
        prev_rd    = bus.mem_rd_o;
        prev_valid = v;
        prev_addr  = bus.mem_addr_o;
        if (bus.ack_o) acks++;
    end

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_fill(input logic [31:0] a, input int wm, input bit b2b, input logic [31:0] a2);
        int            cyc;
        bit            got;
        logic [31:0]   b;
        logic [LB-1:0] exp_addrs;
        logic [LB-1:0] got_addrs;
        wmode = wm;
        wcnt = 0;
        addr_log.delete();
        acks = 0;
        stable_err = 0;
        bus.addr_i = a;
        bus.rd_i = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.ack_o;
        end
        chk("ack_seen", LB'(got), LB'(1));
        chk("line_data", bus.data_o, model_line(a));
        if (wm == 0) chk("zero_wait_latency", LB'(cyc), LB'(LW + 1));
        if (b2b) bus.addr_i = a2;
        else     bus.rd_i = 1'b0;
        @(posedge clk);
        #1;
        chk("ack_count", LB'(acks), LB'(1));
        chk("ack_pulse_end", LB'(bus.ack_o), LB'(0));
        chk("capture_count", LB'(addr_log.size()), LB'(LW));
        chk("addr_stable", LB'(stable_err), LB'(0));
        b = a & ~OMASK;
        exp_addrs = '0;
        got_addrs = '0;
        for (int k = 0; k < LW; k++) begin
            exp_addrs[k*32 +: 32] = b + 32'(4 * k);
            if (k < addr_log.size()) got_addrs[k*32 +: 32] = addr_log[k];
        end
        chk("addr_seq", got_addrs, exp_addrs);
    endtask

    initial begin
        vec_t          vecs[6];
        logic [LB-1:0] saved;
        logic [31:0]   ra;

        vecs[0] = '{32'h00000047, 0, 32'h00000040, 32'h0000005C};
        vecs[1] = '{32'h00000047, 1, 32'h00000040, 32'h0000005C};
        vecs[2] = '{32'hFFFFFFF0, 0, 32'hFFFFFFE0, 32'hFFFFFFFC};
        vecs[3] = '{32'hFFFFFFF0, 1, 32'hFFFFFFE0, 32'hFFFFFFFC};
        vecs[4] = '{32'h12345678, 2, 32'h12345660, 32'h1234567C};
        vecs[5] = '{32'h00000100, 0, 32'h00000100, 32'h0000011C};

        bus.addr_i = '0;
        bus.rd_i = 1'b0;
        bus.mem_valid_i = 1'b0;
        bus.mem_data_i = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", LB'(bus.ack_o), LB'(0));
        chk("rst_mem_rd", LB'(bus.mem_rd_o), LB'(0));
        chk("rst_mem_addr", LB'(bus.mem_addr_o), LB'(0));
        chk("rst_data", bus.data_o, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_fill(vecs[i].addr, vecs[i].wm, 1'b0, '0);
            chk("first_addr", LB'((addr_log.size() > 0) ? addr_log[0] : 32'hx), LB'(vecs[i].first));
            chk("last_addr", LB'((addr_log.size() >= LW) ? addr_log[LW-1] : 32'hx), LB'(vecs[i].last));
        end

        run_fill(32'h000001E0, 0, 1'b1, 32'h00000020);
        run_fill(32'h00000020, 0, 1'b0, '0);

        saved = bus.data_o;
        acks = 0;
        spur = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        spur = 1'b0;
        chk("spur_data_hold", bus.data_o, saved);
        chk("spur_mem_rd", LB'(bus.mem_rd_o), LB'(0));
        chk("spur_no_ack", LB'(acks), LB'(0));
        run_fill(32'h00000060, 0, 1'b0, '0);

        wmode = 0;
        addr_log.delete();
        acks = 0;
        bus.addr_i = 32'h00000300;
        bus.rd_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_abort_words", LB'(addr_log.size()), LB'(3));
        rst = 1'b1;
        bus.rd_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_mem_rd", LB'(bus.mem_rd_o), LB'(0));
        chk("abort_ack", LB'(bus.ack_o), LB'(0));
        chk("abort_data", bus.data_o, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_ack", LB'(acks), LB'(0));
        run_fill(32'h00000100, 0, 1'b0, '0);
        chk("post_abort_first", LB'((addr_log.size() > 0) ? addr_log[0] : 32'hx), LB'(32'h100));

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            run_fill(ra, $urandom_range(0, 2), 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
